// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared memory-op encodings and the pipeline entry record
package core_pkg;

    localparam int CORE_DATA_W = 32;
    localparam int CORE_REG_AW = 5;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LB   = 3'd1,
        MEM_LH   = 3'd2,
        MEM_LW   = 3'd3,
        MEM_SB   = 3'd4,
        MEM_SH   = 3'd5,
        MEM_SW   = 3'd6,
        MEM_RSVD = 3'd7
    } mem_op_e;

    // Constant-width record of one EX/MEM entry at the default core widths.
    typedef struct packed {
        logic                   wreg;
        logic [CORE_REG_AW-1:0] wreg_addr;
        logic [CORE_DATA_W-1:0] wreg_data;
        mem_op_e                mem_op;
        logic [CORE_DATA_W-1:0] mem_addr;
        logic [CORE_DATA_W-1:0] mem_wdata;
    } entry_t;

    // The reserved encoding behaves as "no memory access" once captured.
    function automatic logic [2:0] sanitize_op(input logic [2:0] op);
        return (op == 3'(MEM_RSVD)) ? 3'(MEM_NONE) : op;
    endfunction

    function automatic logic is_load(input logic [2:0] op);
        return (op >= 3'(MEM_LB)) && (op <= 3'(MEM_LW));
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one valid bit plus payload register with load and clear
module pipe_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         unload_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    // Clear wins over load; an unload without a reload just drops the valid bit.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= d_i;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM pipeline register with a skid entry and forwarding tap
module ex_mem_skid
    import core_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wreg,
    input  logic [REG_AW-1:0] in_wreg_addr,
    input  logic [DATA_W-1:0] in_wreg_data,
    input  logic [2:0]        in_mem_op,
    input  logic [DATA_W-1:0] in_mem_addr,
    input  logic [DATA_W-1:0] in_mem_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wreg,
    output logic [REG_AW-1:0] out_wreg_addr,
    output logic [DATA_W-1:0] out_wreg_data,
    output logic [2:0]        out_mem_op,
    output logic [DATA_W-1:0] out_mem_addr,
    output logic [DATA_W-1:0] out_mem_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_load
);
    localparam int PW = 1 + REG_AW + DATA_W + 3 + 2 * DATA_W;

    logic          main_valid, skid_valid;
    logic [PW-1:0] main_q, skid_q, main_d, in_pay;
    logic          accept, transfer, load_main, load_skid, unload_main, unload_skid;

    logic              m_wreg;
    logic [REG_AW-1:0] m_wreg_addr;
    logic [DATA_W-1:0] m_wreg_data;
    logic [2:0]        m_mem_op;
    logic [DATA_W-1:0] m_mem_addr;
    logic [DATA_W-1:0] m_mem_wdata;

    // Writes to x0 and the reserved op are neutralised before they are stored.
    assign in_pay = {in_wreg & (in_wreg_addr != '0), in_wreg_addr, in_wreg_data,
                     sanitize_op(in_mem_op), in_mem_addr, in_mem_wdata};

    // in_ready comes straight from the skid valid flop, so out_ready never reaches it.
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign transfer = main_valid & out_ready;

    // Main refills from skid when one is parked, otherwise from the input.
    always_comb begin
        load_main   = (transfer & skid_valid) | (accept & (~main_valid | transfer));
        unload_main = transfer;
        load_skid   = accept & main_valid & ~transfer;
        unload_skid = transfer & skid_valid;
        main_d      = skid_valid ? skid_q : in_pay;
    end

    pipe_entry #(.W(PW)) u_main (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (flush),
        .load_i   (load_main),
        .unload_i (unload_main),
        .d_i      (main_d),
        .valid_o  (main_valid),
        .q_o      (main_q)
    );

    pipe_entry #(.W(PW)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (flush),
        .load_i   (load_skid),
        .unload_i (unload_skid),
        .d_i      (in_pay),
        .valid_o  (skid_valid),
        .q_o      (skid_q)
    );

    assign {m_wreg, m_wreg_addr, m_wreg_data, m_mem_op, m_mem_addr, m_mem_wdata} = main_q;

    // Side-effect fields are masked when nothing is held so MEM never acts on stale data.
    assign out_valid     = main_valid;
    assign out_wreg      = main_valid & m_wreg;
    assign out_wreg_addr = m_wreg_addr;
    assign out_wreg_data = m_wreg_data;
    assign out_mem_op    = main_valid ? m_mem_op : 3'(MEM_NONE);
    assign out_mem_addr  = m_mem_addr;
    assign out_mem_wdata = m_mem_wdata;

    // Only the main entry forwards; a parked skid entry stalls EX via in_ready.
    assign fwd_valid = out_wreg;
    assign fwd_addr  = m_wreg_addr;
    assign fwd_data  = m_wreg_data;
    assign fwd_load  = fwd_valid & is_load(out_mem_op);

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - directed table-driven bench for ex_mem_skid
module tb_ex_mem_skid;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_wreg, out_valid, out_ready;
    logic [4:0]  in_wreg_addr, out_wreg_addr, fwd_addr;
    logic [31:0] in_wreg_data, in_mem_addr, in_mem_wdata;
    logic [31:0] out_wreg_data, out_mem_addr, out_mem_wdata, fwd_data;
    logic [2:0]  in_mem_op, out_mem_op;
    logic        out_wreg, fwd_valid, fwd_load;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_mem_skid #(.DATA_W(32), .REG_AW(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wreg       (in_wreg),
        .in_wreg_addr  (in_wreg_addr),
        .in_wreg_data  (in_wreg_data),
        .in_mem_op     (in_mem_op),
        .in_mem_addr   (in_mem_addr),
        .in_mem_wdata  (in_mem_wdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_wreg      (out_wreg),
        .out_wreg_addr (out_wreg_addr),
        .out_wreg_data (out_wreg_data),
        .out_mem_op    (out_mem_op),
        .out_mem_addr  (out_mem_addr),
        .out_mem_wdata (out_mem_wdata),
        .fwd_valid     (fwd_valid),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
        .fwd_load      (fwd_load)
    );

    typedef struct {
        logic        rst, flush, iv;
        logic [31:0] wd;
        logic        wreg;
        logic [4:0]  wa;
        logic [2:0]  op;
        logic        ordy;
        logic        ov, ir;
        logic [31:0] od;
        logic        owreg;
        logic [2:0]  oop;
        logic        fv, fl;
        logic [4:0]  fa;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [31:0] wd,
                                input logic wreg, input logic [4:0] wa, input logic [2:0] op,
                                input logic ordy, input logic ov, input logic ir, input logic [31:0] od,
                                input logic owreg, input logic [2:0] oop, input logic fv,
                                input logic fl, input logic [4:0] fa);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.wd = wd; v.wreg = wreg; v.wa = wa; v.op = op;
        v.ordy = ordy; v.ov = ov; v.ir = ir; v.od = od; v.owreg = owreg; v.oop = oop;
        v.fv = fv; v.fl = fl; v.fa = fa;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] wd,
                         input logic wreg, input logic [4:0] wa, input logic [2:0] op, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_wreg = wreg; in_wreg_addr = wa;
        in_wreg_data = wd; in_mem_op = op; in_mem_addr = wd + 32'h100; in_mem_wdata = wd;
        out_ready = ordy;
    endtask

    task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] wd,
                        input logic wreg, input logic [4:0] wa, input logic [2:0] op, input logic ordy);
        @(negedge clk);
        drive(r, f, iv, wd, wreg, wa, op, ordy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 3'd0, 1'b0);

        // reset
        vecs.push_back(mk(1,0,0,32'h0,   0,0,0,0, 0,1,32'h0,  0,0,0,0,0));
        // streaming, 1-cycle latency
        vecs.push_back(mk(0,0,1,32'h11,  1,1,0,1, 1,1,32'h11, 1,0,1,0,1));
        vecs.push_back(mk(0,0,1,32'h22,  1,2,0,1, 1,1,32'h22, 1,0,1,0,2));
        vecs.push_back(mk(0,0,1,32'h33,  1,3,0,1, 1,1,32'h33, 1,0,1,0,3));
        vecs.push_back(mk(0,0,1,32'h44,  1,4,0,1, 1,1,32'h44, 1,0,1,0,4));
        vecs.push_back(mk(0,0,0,32'h0,   0,0,0,1, 0,1,32'h0,  0,0,0,0,0));
        // backpressure: main 0x11, skid 0x22, 0x33 stays offered
        vecs.push_back(mk(0,0,1,32'h11,  1,1,0,0, 1,1,32'h11, 1,0,1,0,1));
        vecs.push_back(mk(0,0,1,32'h22,  1,2,0,0, 1,0,32'h11, 1,0,1,0,1));
        vecs.push_back(mk(0,0,1,32'h33,  1,3,0,0, 1,0,32'h11, 1,0,1,0,1));
        vecs.push_back(mk(0,0,1,32'h33,  1,3,0,1, 1,1,32'h22, 1,0,1,0,2));
        vecs.push_back(mk(0,0,1,32'h33,  1,3,0,1, 1,1,32'h33, 1,0,1,0,3));
        vecs.push_back(mk(0,0,0,32'h0,   0,0,0,1, 0,1,32'h0,  0,0,0,0,0));
        // flush with both entries full and a same-cycle offer of 0x55
        vecs.push_back(mk(0,0,1,32'h11,  1,1,0,0, 1,1,32'h11, 1,0,1,0,1));
        vecs.push_back(mk(0,0,1,32'h22,  1,2,0,0, 1,0,32'h11, 1,0,1,0,1));
        vecs.push_back(mk(0,1,1,32'h55,  1,5,0,0, 0,1,32'h0,  0,0,0,0,0));
        vecs.push_back(mk(0,0,0,32'h0,   0,0,0,1, 0,1,32'h0,  0,0,0,0,0));
        // x0 write with reserved op
        vecs.push_back(mk(0,0,1,32'h66,  1,0,7,0, 1,1,32'h66, 0,0,0,0,0));
        vecs.push_back(mk(0,0,0,32'h0,   0,0,0,1, 0,1,32'h0,  0,0,0,0,0));
        // forwarding: LW to x5, then ADD 0xDEAD to x7
        vecs.push_back(mk(0,0,1,32'h1234,1,5,3,0, 1,1,32'h1234,1,3,1,1,5));
        vecs.push_back(mk(0,0,1,32'hDEAD,1,7,0,1, 1,1,32'hDEAD,1,0,1,0,7));
        // store without writeback
        vecs.push_back(mk(0,0,1,32'h77,  0,9,6,1, 1,1,32'h77, 0,6,0,0,9));
        vecs.push_back(mk(0,0,0,32'h0,   0,0,0,1, 0,1,32'h0,  0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            step(v.rst, v.flush, v.iv, v.wd, v.wreg, v.wa, v.op, v.ordy);
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(v.ov));
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(v.ir));
            check($sformatf("v%0d out_wreg", i), 32'(out_wreg), 32'(v.owreg));
            check($sformatf("v%0d out_mem_op", i), 32'(out_mem_op), 32'(v.oop));
            check($sformatf("v%0d fwd_valid", i), 32'(fwd_valid), 32'(v.fv));
            check($sformatf("v%0d fwd_load", i), 32'(fwd_load), 32'(v.fl));
            if (v.ov) begin
                check($sformatf("v%0d out_mem_wdata", i), out_mem_wdata, v.od);
                check($sformatf("v%0d out_mem_addr", i), out_mem_addr, v.od + 32'h100);
                check($sformatf("v%0d fwd_addr", i), 32'(fwd_addr), 32'(v.fa));
            end
            if (v.fv)
                check($sformatf("v%0d fwd_data", i), fwd_data, v.od);
        end

        // reset while both entries are full and the MEM side is stalled
        step(0, 0, 1, 32'hA1, 1, 3, 3, 0);
        step(0, 0, 1, 32'hA2, 1, 4, 6, 0);
        check("rst_mid in_ready before", 32'(in_ready), 32'd0);
        step(1, 0, 1, 32'hA3, 1, 6, 2, 1);
        check("rst_mid out_valid", 32'(out_valid), 32'd0);
        check("rst_mid in_ready", 32'(in_ready), 32'd1);
        check("rst_mid out_wreg", 32'(out_wreg), 32'd0);
        check("rst_mid out_mem_op", 32'(out_mem_op), 32'd0);
        check("rst_mid out_mem_addr", out_mem_addr, 32'd0);
        check("rst_mid out_mem_wdata", out_mem_wdata, 32'd0);
        check("rst_mid out_wreg_data", out_wreg_data, 32'd0);
        check("rst_mid fwd_valid", 32'(fwd_valid), 32'd0);
        check("rst_mid fwd_addr", 32'(fwd_addr), 32'd0);
        check("rst_mid fwd_data", fwd_data, 32'd0);
        step(0, 0, 0, 32'h0, 0, 0, 0, 1);
        check("rst_mid in_ready after", 32'(in_ready), 32'd1);
        check("rst_mid out_valid after", 32'(out_valid), 32'd0);

        // hold: out fields stay stable across several stalled cycles
        step(0, 0, 1, 32'hB0, 1, 2, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 32'h0, 0, 0, 0, 0);
            check($sformatf("hold%0d out_mem_wdata", k), out_mem_wdata, 32'hB0);
            check($sformatf("hold%0d out_mem_op", k), 32'(out_mem_op), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register-data, memory-address and store-data width.
REQ-002 SHALL have parameter REG_AW, default 5, register-file address width.
REQ-003 SHALL have port clk input 1: clock; all state updates on rising edge.
REQ-004 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-005 SHALL have port flush input 1: discard all held entries.
REQ-006 SHALL have port in_valid input 1: EX presents an instruction.
REQ-007 SHALL have port in_ready output 1: stage accepts this cycle.
REQ-008 SHALL have port in_wreg input 1, in_wreg_addr input REG_AW, in_wreg_data input DATA_W: writeback request.
REQ-009 SHALL have port in_mem_op input 3: 0 none, 1 LB, 2 LH, 3 LW, 4 SB, 5 SH, 6 SW, 7 reserved (treated as none).
REQ-010 SHALL have port in_mem_addr input DATA_W and in_mem_wdata input DATA_W.
REQ-011 SHALL have port out_valid output 1 and out_ready input 1: MEM-side handshake.
REQ-012 SHALL have ports out_wreg 1, out_wreg_addr REG_AW, out_wreg_data DATA_W, out_mem_op 3, out_mem_addr DATA_W, out_mem_wdata DATA_W, all outputs.
REQ-013 SHALL have ports fwd_valid output 1, fwd_addr output REG_AW, fwd_data output DATA_W, fwd_load output 1: EX forwarding source.

Function
REQ-014 SHALL hold two entries: main (drives out_*) and skid.
REQ-015 SHALL drive in_ready = NOT skid_valid, from a register only (no combinational path from out_ready).
REQ-016 SHALL accept on in_valid AND in_ready; transfer out on out_valid AND out_ready.
REQ-017 SHALL, on accept with main empty or main transferring and skid empty, load main next cycle (latency 1).
REQ-018 SHALL, on accept while main holds and does not transfer, load skid.
REQ-019 SHALL, on transfer with skid full, move skid to main and clear skid in the same edge.
REQ-020 SHALL keep out_* stable while out_valid AND NOT out_ready.
REQ-021 SHALL, on flush, clear main_valid and skid_valid next edge; a same-cycle accept is dropped; flush overrides all.
REQ-022 SHALL zero out_wreg and out_mem_op whenever out_valid is 0; data fields then don't-care.
REQ-023 SHALL force stored wreg to 0 when in_wreg_addr is 0.
REQ-024 SHALL map in_mem_op 7 to 0 on capture.
REQ-025 SHALL drive fwd_valid = main_valid AND out_wreg; fwd_addr/fwd_data from main; fwd_load = fwd_valid AND out_mem_op in 1..3.
REQ-026 SHALL flag nothing for skid entry forwarding; EX stalls via in_ready.

Reset
REQ-027 SHALL, while rst high at an edge, clear main_valid, skid_valid, all out_* fields, fwd_* to 0.
REQ-028 SHALL drive in_ready 1 from the first edge after rst deasserts; rst mid-transfer discards both entries.
REQ-029 SHALL give rst priority over flush and accept.

Structure
REQ-030 SHALL place mem_op encodings (MEM_NONE..MEM_SW) and a constant-width entry record in shared package core_pkg.
REQ-031 SHALL implement each entry as one sub-module instance pipe_entry (valid bit + payload register with load enable and clear).
REQ-032 SHALL contain no combinational path from out_ready to in_ready.

Verification
REQ-033 SHALL test streaming: out_ready=1, 4 back-to-back inputs wdata 0x11..0x44 -> outputs 0x11..0x44 on consecutive cycles, 1-cycle latency, in_ready stays 1.
REQ-034 SHALL test backpressure: out_ready=0 with 3 inputs -> first two held (main 0x11, skid 0x22), in_ready 0, third stays offered; release -> 0x11,0x22,0x33 in order, none lost.
REQ-035 SHALL test flush: both entries full, flush with in_valid=1 wdata 0x55 -> next cycle out_valid 0, in_ready 1, 0x55 never appears.
REQ-036 SHALL test x0 write and reserved op: in_wreg=1 addr 0, mem_op 7 -> out_wreg 0, out_mem_op 0, fwd_valid 0.
REQ-037 SHALL test forwarding: LW to addr 5 in main -> fwd_valid 1, fwd_addr 5, fwd_load 1; ADD result 0xDEAD to addr 7 -> fwd_load 0, fwd_data 0xDEAD.
REQ-038 SHALL test reset mid-stall: both entries full, rst 1 cycle -> all outputs 0, in_ready 1 next cycle.
